register_bank: RTL and testbench



---
 rtl/register_bank.sv | 94 +++++++++
 tb/tb_register_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module      : register_bank
// Description : DEPTH x WIDTH edge-triggered register bank with one write
//               port and two independent registered read ports. Each read
//               port also drives the bitwise complement of its data.
//               Optional macro REGBANK_FWD_EN: a read of the address being
//               written on the same edge returns the new write data.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_a_n,
  output logic             valid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [WIDTH-1:0] rdata_b_n,
  output logic             valid_b
);

  localparam logic [WIDTH-1:0] c_zero = '0;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

`ifdef REGBANK_FWD_EN
  // Write-through: a same-edge read of the written address sees the new data
  assign w_rd_a = (we && (waddr == raddr_a)) ? wdata : r_mem[raddr_a];
  assign w_rd_b = (we && (waddr == raddr_b)) ? wdata : r_mem[raddr_b];
`else
  // Reads always see the pre-edge contents of the array
  assign w_rd_a = r_mem[raddr_a];
  assign w_rd_b = r_mem[raddr_b];
`endif

  // Storage array: clear has priority over the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= c_zero;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= c_zero;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port A: data holds when idle, valid marks a read from the last edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= c_zero;
      valid_a <= 1'b0;
    end else if (clr) begin
      rdata_a <= c_zero;
      valid_a <= 1'b0;
    end else begin
      valid_a <= re_a;
      if (re_a) rdata_a <= w_rd_a;
    end
  end

  // Read port B: identical behaviour to port A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_b <= c_zero;
      valid_b <= 1'b0;
    end else if (clr) begin
      rdata_b <= c_zero;
      valid_b <= 1'b0;
    end else begin
      valid_b <= re_b;
      if (re_b) rdata_b <= w_rd_b;
    end
  end

  // Complemented outputs are derived, never stored separately
  assign rdata_a_n = ~rdata_a;
  assign rdata_b_n = ~rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank
// Description : Self-checking bench for register_bank. Table of per-cycle
//               vectors for the 8x8 instance, hand sequences for reset and
//               a 16x4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit x 8-word instance
  logic       rst_n, clr, we, re_a, re_b;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] wdata, rdata_a, rdata_a_n, rdata_b, rdata_b_n;
  logic       valid_a, valid_b;

  register_bank #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rdata_a_n(rdata_a_n), .valid_a(valid_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rdata_b_n(rdata_b_n), .valid_b(valid_b)
  );

  // 16-bit x 4-word instance
  logic        clr16, we16, re_a16, re_b16;
  logic [1:0]  waddr16, raddr_a16, raddr_b16;
  logic [15:0] wdata16, rdata_a16, rdata_a16_n, rdata_b16, rdata_b16_n;
  logic        valid_a16, valid_b16;

  register_bank #(.WIDTH(16), .DEPTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr16), .we(we16), .waddr(waddr16), .wdata(wdata16),
    .re_a(re_a16), .raddr_a(raddr_a16), .rdata_a(rdata_a16), .rdata_a_n(rdata_a16_n), .valid_a(valid_a16),
    .re_b(re_b16), .raddr_b(raddr_b16), .rdata_b(rdata_b16), .rdata_b_n(rdata_b16_n), .valid_b(valid_b16)
  );

`ifdef REGBANK_FWD_EN
  localparam logic [7:0] c_same_edge = 8'h3C;
`else
  localparam logic [7:0] c_same_edge = 8'h00;
`endif

  typedef struct {
    logic       clr;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;
    logic [7:0] exp_a;
    logic       exp_va;
    logic [7:0] exp_b;
    logic       exp_vb;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic c, logic w, logic [2:0] wa, logic [7:0] wd,
                              logic ra, logic [2:0] aa, logic rb, logic [2:0] ab,
                              logic [7:0] ea, logic eva, logic [7:0] eb, logic evb);
    vec_t v;
    v.clr = c; v.we = w; v.waddr = wa; v.wdata = wd;
    v.re_a = ra; v.raddr_a = aa; v.re_b = rb; v.raddr_b = ab;
    v.exp_a = ea; v.exp_va = eva; v.exp_b = eb; v.exp_vb = evb;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle8();
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
  endtask

  initial begin
    //           clr we wa    wd     ra aa    rb ab    exp_a  va  exp_b  vb
    vecs[0]  = mk(0, 1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0, 8'h00, 0, 8'h00, 0);
    vecs[1]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd3, 0, 3'd0, 8'hA5, 1, 8'h00, 0);
    vecs[2]  = mk(0, 0, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0, 8'hA5, 0, 8'h00, 0);
    vecs[3]  = mk(0, 1, 3'd1, 8'h11, 0, 3'd0, 0, 3'd0, 8'hA5, 0, 8'h00, 0);
    vecs[4]  = mk(0, 1, 3'd6, 8'h66, 0, 3'd0, 1, 3'd3, 8'hA5, 0, 8'hA5, 1);
    vecs[5]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd1, 1, 3'd6, 8'h11, 1, 8'h66, 1);
    vecs[6]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd6, 1, 3'd6, 8'h66, 1, 8'h66, 1);
    vecs[7]  = mk(0, 1, 3'd2, 8'h3C, 1, 3'd2, 1, 3'd2, c_same_edge, 1, c_same_edge, 1);
    vecs[8]  = mk(0, 0, 3'd0, 8'h00, 1, 3'd2, 0, 3'd0, 8'h3C, 1, c_same_edge, 0);
    vecs[9]  = mk(1, 1, 3'd5, 8'h77, 1, 3'd3, 1, 3'd6, 8'h00, 0, 8'h00, 0);
    vecs[10] = mk(0, 0, 3'd0, 8'h00, 1, 3'd3, 1, 3'd5, 8'h00, 1, 8'h00, 1);
    vecs[11] = mk(0, 0, 3'd0, 8'h00, 1, 3'd6, 1, 3'd1, 8'h00, 1, 8'h00, 1);

    idle8();
    clr16 = 1'b0; we16 = 1'b0; waddr16 = '0; wdata16 = '0;
    re_a16 = 1'b0; raddr_a16 = '0; re_b16 = 1'b0; raddr_b16 = '0;
    rst_n = 1'b0;
    #12;
    check("reset_rdata_a",   {8'h0, rdata_a},   16'h0000);
    check("reset_rdata_a_n", {8'h0, rdata_a_n}, 16'h00FF);
    check("reset_valid_a",   {15'h0, valid_a},  16'h0000);
    check("reset_rdata_b_n", {8'h0, rdata_b_n}, 16'h00FF);
    check("reset_valid_b",   {15'h0, valid_b},  16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors: drive at negedge, check at the following negedge
    for (int i = 0; i < NV; i++) begin
      clr = vecs[i].clr; we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re_a = vecs[i].re_a; raddr_a = vecs[i].raddr_a;
      re_b = vecs[i].re_b; raddr_b = vecs[i].raddr_b;
      @(negedge clk);
      check($sformatf("v%0d_rdata_a", i),   {8'h0, rdata_a},   {8'h0, vecs[i].exp_a});
      check($sformatf("v%0d_rdata_a_n", i), {8'h0, rdata_a_n}, {8'h0, ~vecs[i].exp_a});
      check($sformatf("v%0d_valid_a", i),   {15'h0, valid_a},  {15'h0, vecs[i].exp_va});
      check($sformatf("v%0d_rdata_b", i),   {8'h0, rdata_b},   {8'h0, vecs[i].exp_b});
      check($sformatf("v%0d_rdata_b_n", i), {8'h0, rdata_b_n}, {8'h0, ~vecs[i].exp_b});
      check($sformatf("v%0d_valid_b", i),   {15'h0, valid_b},  {15'h0, vecs[i].exp_vb});
    end

    // Asynchronous reset mid-cycle after nonzero contents
    idle8();
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
    @(negedge clk);
    idle8();
    re_a = 1'b1; raddr_a = 3'd0;
    @(negedge clk);
    check("pre_reset_rdata_a", {8'h0, rdata_a}, 16'h00FF);
    idle8();
    #2 rst_n = 1'b0;
    #1;
    check("async_rdata_a",   {8'h0, rdata_a},   16'h0000);
    check("async_rdata_a_n", {8'h0, rdata_a_n}, 16'h00FF);
    check("async_valid_a",   {15'h0, valid_a},  16'h0000);
    // A write presented while reset is held must be discarded
    we = 1'b1; waddr = 3'd4; wdata = 8'h99;
    re_a = 1'b1; raddr_a = 3'd0;
    @(negedge clk);
    check("held_valid_a", {15'h0, valid_a}, 16'h0000);
    idle8();
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      re_a = 1'b1; raddr_a = a[2:0];
      @(negedge clk);
      check($sformatf("post_reset_addr%0d", a), {8'h0, rdata_a}, 16'h0000);
      check($sformatf("post_reset_valid%0d", a), {15'h0, valid_a}, 16'h0001);
    end
    idle8();

    // 16-bit x 4-word instance: writes to other addresses leave addr 3 intact
    we16 = 1'b1; waddr16 = 2'd3; wdata16 = 16'hBEEF;
    @(negedge clk);
    waddr16 = 2'd0; wdata16 = 16'h1234;
    @(negedge clk);
    we16 = 1'b0;
    re_a16 = 1'b1; raddr_a16 = 2'd3; re_b16 = 1'b1; raddr_b16 = 2'd0;
    @(negedge clk);
    check("w16_addr3",     rdata_a16,          16'hBEEF);
    check("w16_addr3_n",   rdata_a16_n,        16'h4110);
    check("w16_addr0",     rdata_b16,          16'h1234);
    check("w16_addr0_n",   rdata_b16_n,        16'hEDCB);
    check("w16_valid_a",   {15'h0, valid_a16}, 16'h0001);
    check("w16_valid_b",   {15'h0, valid_b16}, 16'h0001);
    re_a16 = 1'b0; re_b16 = 1'b0;
    @(negedge clk);
    check("w16_hold_a",    rdata_a16,          16'hBEEF);
    check("w16_idle_va",   {15'h0, valid_a16}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
